// File: rtl/bxu_core.sv
// bxu_core: Brainfuck-style execution unit driving a code ROM, a byte data RAM and an rx/tx byte interface.
// Latency: pointer moves, jumps and NOPs take 1 cycle; +/- take 2 cycles; bracket scans walk 1 instruction per cycle.
// Backpressure: ',' stalls until an input byte is buffered; '.' holds io_output_ready until io_output_done rises, then waits for it to fall.
// Ports: clk/rst (sync, active-high); code_addr/code_in (ROM, combinational read);
//        data_addr/data_in/data_out/data_wr (RAM, async read, level write); io_input_* (rx byte + strobe,
//        consume pulse); io_output_ready/io_output_done (tx byte on data_out); dbg_clk (reserved, unused).
module bxu_core #(
  parameter int DATA_BITWIDTH = 8,
  parameter int CODE_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_BITWIDTH-1:0] code_addr,
  input  logic [CODE_BITWIDTH-1:0] code_in,
  output logic [ADDR_BITWIDTH-1:0] data_addr,
  input  logic [DATA_BITWIDTH-1:0] data_in,
  output logic [DATA_BITWIDTH-1:0] data_out,
  output logic                     data_wr,
  input  logic [DATA_BITWIDTH-1:0] io_input_data,
  input  logic                     io_input_ready,
  output logic                     io_input_done,
  output logic                     io_output_ready,
  input  logic                     io_output_done,
  input  logic                     dbg_clk
);

  typedef enum logic [2:0] {
    S_EXEC, S_WRITE, S_IN_WAIT, S_OUT_WAIT, S_OUT_REL, S_SCAN_F, S_SCAN_B, S_HALT
  } state_t;

  localparam logic [7:0] OP_INC_DP = 8'h3E;
  localparam logic [7:0] OP_DEC_DP = 8'h3C;
  localparam logic [7:0] OP_INC    = 8'h2B;
  localparam logic [7:0] OP_DEC    = 8'h2D;
  localparam logic [7:0] OP_OUT    = 8'h2E;
  localparam logic [7:0] OP_IN     = 8'h2C;
  localparam logic [7:0] OP_LOOP   = 8'h5B;
  localparam logic [7:0] OP_END    = 8'h5D;
  localparam logic [7:0] OP_HALT   = 8'h00;

  localparam logic [ADDR_BITWIDTH-1:0] A_ONE = ADDR_BITWIDTH'(1);
  localparam logic [DATA_BITWIDTH-1:0] D_ONE = DATA_BITWIDTH'(1);

  state_t                     state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_BITWIDTH-1:0]   dp_q, dp_d;
  logic [ADDR_BITWIDTH-1:0]   depth_q, depth_d;
  logic [DATA_BITWIDTH-1:0]   wval_q, wval_d;
  logic [DATA_BITWIDTH-1:0]   buf_q, buf_d;
  logic                       full_q, full_d;

  logic [7:0]                 op;
  logic                       in_avail;
  logic [DATA_BITWIDTH-1:0]   in_byte;
  logic                       unused_ok;

  // Only the low byte carries the opcode; the debug clock is deliberately ignored.
  assign op        = code_in[7:0];
  assign unused_ok = ^{dbg_clk, code_in[CODE_BITWIDTH-1:8]};

  // A strobe in the same cycle as IN_WAIT is consumed directly, bypassing the buffer.
  assign in_avail = full_q | io_input_ready;
  assign in_byte  = io_input_ready ? io_input_data : buf_q;

  assign code_addr       = pc_q;
  assign data_addr       = dp_q;
  assign data_wr         = (state_q == S_WRITE);
  assign data_out        = (state_q == S_WRITE) ? wval_q : data_in;
  assign io_output_ready = (state_q == S_OUT_WAIT);
  assign io_input_done   = (state_q == S_IN_WAIT) & in_avail & ~rst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dp_d    = dp_q;
    depth_d = depth_q;
    wval_d  = wval_q;
    buf_d   = buf_q;
    full_d  = full_q;

    if (io_input_ready) begin
      buf_d  = io_input_data;
      full_d = 1'b1;
    end

    unique case (state_q)
      S_EXEC: begin
        case (op)
          OP_INC_DP: begin dp_d = dp_q + A_ONE; pc_d = pc_q + A_ONE; end
          OP_DEC_DP: begin dp_d = dp_q - A_ONE; pc_d = pc_q + A_ONE; end
          OP_INC:    begin wval_d = data_in + D_ONE; state_d = S_WRITE; end
          OP_DEC:    begin wval_d = data_in - D_ONE; state_d = S_WRITE; end
          OP_IN:     state_d = S_IN_WAIT;
          OP_OUT:    state_d = S_OUT_WAIT;
          OP_LOOP: begin
            pc_d = pc_q + A_ONE;
            if (data_in == '0) begin
              depth_d = A_ONE;
              state_d = S_SCAN_F;
            end
          end
          OP_END: begin
            if (data_in != '0) begin
              depth_d = A_ONE;
              pc_d    = pc_q - A_ONE;
              state_d = S_SCAN_B;
            end else begin
              pc_d = pc_q + A_ONE;
            end
          end
          OP_HALT:   state_d = S_HALT;
          default:   pc_d = pc_q + A_ONE;
        endcase
      end

      // pc advances here rather than at decode so +, - and , all retire from one place.
      S_WRITE: begin
        pc_d    = pc_q + A_ONE;
        state_d = S_EXEC;
      end

      S_IN_WAIT: begin
        if (in_avail) begin
          wval_d  = in_byte;
          full_d  = 1'b0;
          state_d = S_WRITE;
        end
      end

      S_OUT_WAIT: begin
        if (io_output_done) state_d = S_OUT_REL;
      end

      // Waiting for done to fall makes a multi-cycle done count as one acceptance.
      S_OUT_REL: begin
        if (!io_output_done) begin
          pc_d    = pc_q + A_ONE;
          state_d = S_EXEC;
        end
      end

      S_SCAN_F: begin
        case (op)
          OP_HALT: state_d = S_HALT;
          OP_LOOP: begin depth_d = depth_q + A_ONE; pc_d = pc_q + A_ONE; end
          OP_END: begin
            pc_d = pc_q + A_ONE;
            if (depth_q == A_ONE) state_d = S_EXEC;
            else                  depth_d = depth_q - A_ONE;
          end
          default: pc_d = pc_q + A_ONE;
        endcase
      end

      // Walks backwards; on the matching '[' execution resumes just after it.
      S_SCAN_B: begin
        case (op)
          OP_HALT: state_d = S_HALT;
          OP_END: begin depth_d = depth_q + A_ONE; pc_d = pc_q - A_ONE; end
          OP_LOOP: begin
            if (depth_q == A_ONE) begin
              pc_d    = pc_q + A_ONE;
              state_d = S_EXEC;
            end else begin
              depth_d = depth_q - A_ONE;
              pc_d    = pc_q - A_ONE;
            end
          end
          default: pc_d = pc_q - A_ONE;
        endcase
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EXEC;
      pc_q    <= '0;
      dp_q    <= '0;
      depth_q <= '0;
      wval_q  <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dp_q    <= dp_d;
      depth_q <= depth_d;
      wval_q  <= wval_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_bxu_core.sv
// tb_bxu_core: self-checking bench for bxu_core with ROM/RAM models, a tx responder and a program-level reference interpreter.
// Latency: n/a (bench).
// Backpressure: the tx responder acknowledges each output a few cycles late with a 2-cycle done pulse.
module tb_bxu_core;
  logic        clk = 1'b0;
  logic        dbg_clk = 1'b0;
  logic        rst;
  logic [15:0] code_addr, data_addr;
  logic [15:0] code_in;
  logic [7:0]  data_in, data_out, io_input_data;
  logic        data_wr, io_input_ready, io_input_done, io_output_ready, io_output_done;

  logic [15:0] rom  [0:65535];
  logic [7:0]  ram  [0:65535];
  logic [7:0]  mram [0:65535];

  int n_chk = 0;
  int n_err = 0;

  // Reference results of the interpreter
  logic [15:0] exp_wa[$];
  logic [7:0]  exp_wd[$];
  logic [7:0]  exp_o[$];
  logic [7:0]  got_o[$];
  logic [15:0] exp_pc, exp_dp;
  int          exp_in;
  int          in_cnt, wr_cnt;

  logic        chk_en = 1'b0;
  logic        resp_en = 1'b1;
  logic        prev_rdy = 1'b0;
  logic        prev_done = 1'b0;
  logic [7:0]  cur_o = 8'h00;

  bxu_core #(.DATA_BITWIDTH(8), .CODE_BITWIDTH(16), .ADDR_BITWIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .code_addr(code_addr), .code_in(code_in),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out), .data_wr(data_wr),
    .io_input_data(io_input_data), .io_input_ready(io_input_ready), .io_input_done(io_input_done),
    .io_output_ready(io_output_ready), .io_output_done(io_output_done),
    .dbg_clk(dbg_clk)
  );

  always #5 clk = ~clk;
  always #7 dbg_clk = ~dbg_clk;

  assign code_in = rom[code_addr];
  assign data_in = ram[data_addr];

  always @(negedge clk) if (data_wr) ram[data_addr] = data_out;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: event occurred, none required", nm);
  endfunction

  function automatic void clear_mem();
    for (int i = 0; i < 65536; i++) begin
      rom[i] = 16'h0000; ram[i] = 8'h00; mram[i] = 8'h00;
    end
  endfunction

  // Upper instruction byte carries noise: the core must ignore it.
  function automatic void load_prog(input string s);
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    for (int i = 0; i < s.len(); i++) rom[i] = {8'(i * 29 + 1), s[i]};
  endfunction

  function automatic void set_cell(input logic [15:0] a, input logic [7:0] v);
    ram[a] = v; mram[a] = v;
  endfunction

  // Program-level interpreter: bracket matching by direct search, no cycle timing.
  task automatic run_model(input logic [7:0] inb);
    logic [15:0] pc, dp;
    logic [7:0]  op, c;
    int          depth, steps;
    bit          halted;
    pc = 0; dp = 0; steps = 0; halted = 0;
    exp_wa.delete(); exp_wd.delete(); exp_o.delete(); exp_in = 0;
    while (!halted && steps < 100000) begin
      steps++;
      op = rom[pc][7:0];
      c  = mram[dp];
      case (op)
        8'h3E: begin dp++; pc++; end
        8'h3C: begin dp--; pc++; end
        8'h2B: begin mram[dp] = c + 8'd1; exp_wa.push_back(dp); exp_wd.push_back(c + 8'd1); pc++; end
        8'h2D: begin mram[dp] = c - 8'd1; exp_wa.push_back(dp); exp_wd.push_back(c - 8'd1); pc++; end
        8'h2C: begin mram[dp] = inb; exp_wa.push_back(dp); exp_wd.push_back(inb); exp_in++; pc++; end
        8'h2E: begin exp_o.push_back(c); pc++; end
        8'h5B: begin
          pc++;
          if (c == 8'h00) begin
            depth = 1;
            while (depth > 0 && !halted && steps < 100000) begin
              steps++;
              op = rom[pc][7:0];
              if (op == 8'h00) halted = 1;
              else begin
                if (op == 8'h5B) depth++;
                else if (op == 8'h5D) depth--;
                pc++;
              end
            end
          end
        end
        8'h5D: begin
          if (c != 8'h00) begin
            depth = 1;
            pc--;
            while (depth > 0 && !halted && steps < 100000) begin
              steps++;
              op = rom[pc][7:0];
              if (op == 8'h00) halted = 1;
              else begin
                if (op == 8'h5D) depth++;
                else if (op == 8'h5B) depth--;
                if (depth == 0) pc++; else pc--;
              end
            end
          end else pc++;
        end
        8'h00: halted = 1;
        default: pc++;
      endcase
    end
    exp_pc = pc;
    exp_dp = dp;
  endtask

  // Compare process: every write, every output phase and every handshake edge against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (data_wr) begin
        wr_cnt++;
        if (exp_wa.size() == 0) fail("unexpected_write");
        else begin
          chk("wr_addr", data_addr, exp_wa.pop_front());
          chk("wr_data", data_out, exp_wd.pop_front());
        end
      end
      if (io_output_ready && !prev_rdy) begin
        chk("rise_after_release", prev_done, 1'b0);
        got_o.push_back(data_out);
        if (exp_o.size() == 0) fail("unexpected_output");
        else begin
          cur_o = exp_o.pop_front();
          chk("out_data", data_out, cur_o);
        end
      end else if (io_output_ready) chk("out_hold", data_out, cur_o);
      if (prev_rdy && prev_done)  chk("rdy_drop", io_output_ready, 1'b0);
      if (prev_rdy && !prev_done) chk("rdy_hold", io_output_ready, 1'b1);
      if (io_input_done) in_cnt++;
    end
    prev_rdy  = io_output_ready;
    prev_done = io_output_done;
  end

  // tx responder: acknowledge 2 cycles late, hold done for 2 cycles.
  initial begin
    io_output_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && io_output_ready) begin
        repeat (2) @(posedge clk);
        #1 io_output_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 io_output_done = 1'b0;
      end
    end
  end

  task automatic run(input logic [7:0] inb, input int strobe_at, input int ncyc);
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_code_addr", code_addr, 16'h0000);
    chk("rst_data_addr", data_addr, 16'h0000);
    chk("rst_data_wr", data_wr, 1'b0);
    chk("rst_out_rdy", io_output_ready, 1'b0);
    chk("rst_in_done", io_input_done, 1'b0);
    run_model(inb);
    got_o.delete(); in_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (i == strobe_at) begin io_input_data = inb; io_input_ready = 1'b1; end
      @(posedge clk); #1 io_input_ready = 1'b0;
    end
    @(negedge clk);
    chk("end_pc", code_addr, exp_pc);
    chk("end_dp", data_addr, exp_dp);
    chk("writes_left", exp_wa.size(), 0);
    chk("outputs_left", exp_o.size(), 0);
    chk("in_done_count", in_cnt, exp_in);
    chk("halt_wr", data_wr, 1'b0);
    chk("halt_rdy", io_output_ready, 1'b0);
    repeat (4) @(negedge clk);
    chk("pc_frozen", code_addr, exp_pc);
    chk("cell0_model", ram[0], mram[0]);
    chk("cell1_model", ram[1], mram[1]);
  endtask

  initial begin
    rst = 1'b1; io_input_ready = 1'b0; io_input_data = 8'h00;

    // Input then two outputs, strobe while waiting in IN_WAIT
    clear_mem(); load_prog(",..");
    run(8'hAA, 5, 80);
    chk("t2_cell0", ram[0], 8'hAA);
    chk("t2_nout", got_o.size(), 2);
    if (got_o.size() == 2) begin chk("t2_out0", got_o[0], 8'hAA); chk("t2_out1", got_o[1], 8'hAA); end
    chk("t2_pc", code_addr, 16'd3);
    chk("t2_wr_pulses", wr_cnt, 1);
    chk("t2_in_done", in_cnt, 1);

    // Byte strobed 20 cycles before ',' is fetched: must wait in the buffer
    clear_mem(); load_prog({"                    ", ",.."});
    run(8'hEE, 0, 100);
    chk("t3_nout", got_o.size(), 2);
    if (got_o.size() == 2) begin chk("t3_out0", got_o[0], 8'hEE); chk("t3_out1", got_o[1], 8'hEE); end
    chk("t3_pc", code_addr, 16'd23);

    // Increment, pointer move, decrement with wrap
    clear_mem(); load_prog("+++>--.");
    run(8'h00, -1, 80);
    chk("t4_cell0", ram[0], 8'h03);
    chk("t4_cell1", ram[1], 8'hFE);
    chk("t4_dp", data_addr, 16'h0001);
    if (got_o.size() == 1) chk("t4_out", got_o[0], 8'hFE); else chk("t4_nout", got_o.size(), 1);

    // Loop with backward scans
    clear_mem(); load_prog("+++[->++<]>.");
    run(8'h00, -1, 300);
    chk("t5_cell0", ram[0], 8'h00);
    chk("t5_cell1", ram[1], 8'h06);
    if (got_o.size() == 1) chk("t5_out", got_o[0], 8'h06); else chk("t5_nout", got_o.size(), 1);

    // dp wraps below zero
    clear_mem(); load_prog("<."); set_cell(16'hFFFF, 8'h5A);
    run(8'h00, -1, 40);
    chk("t5b_dp", data_addr, 16'hFFFF);
    if (got_o.size() == 1) chk("t5b_out", got_o[0], 8'h5A); else chk("t5b_nout", got_o.size(), 1);

    // Nested forward skip over a zero cell
    clear_mem(); load_prog("[[+]+].");
    run(8'h00, -1, 60);
    chk("t6_writes", wr_cnt, 0);
    chk("t6_pc", code_addr, 16'd7);
    if (got_o.size() == 1) chk("t6_out", got_o[0], 8'h00); else chk("t6_nout", got_o.size(), 1);

    // Unmatched '[' over a zero cell halts on the terminator
    clear_mem(); load_prog("[");
    run(8'h00, -1, 20);
    chk("t6b_pc", code_addr, 16'd1);

    // Unmatched ']' over a nonzero cell scans back, pc wraps, halts at 0xFFFF
    clear_mem(); load_prog("+]");
    run(8'h00, -1, 20);
    chk("t6c_pc", code_addr, 16'hFFFF);

    // Reset mid-output aborts the wait and clears a buffered input byte
    chk_en = 1'b0; resp_en = 1'b0;
    clear_mem(); load_prog(".");
    rst = 1'b1; repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t7_rdy_before", io_output_ready, 1'b1);
    io_input_data = 8'h55; io_input_ready = 1'b1;
    @(posedge clk); #1 io_input_ready = 1'b0;
    load_prog(",");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rdy_reset", io_output_ready, 1'b0);
    chk("t7_wr_reset", data_wr, 1'b0);
    chk("t7_pc_reset", code_addr, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t7_no_in_done", io_input_done, 1'b0);
      chk("t7_no_wr", data_wr, 1'b0);
    end
    chk("t7_pc_wait", code_addr, 16'h0000);
    resp_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bxu_core.md
Name: bxu_core

Overview:
- Brainfuck-style execution unit: fetches 16-bit instructions from an external combinational code ROM.
- Operates on byte cells in an external data RAM that has asynchronous read and level-sensitive write.
- Exchanges bytes with an I/O block through ready/done handshakes.
- Sits between the program ROM, the data RAM and the UART-style rx/tx front end.

Parameters:
DATA_BITWIDTH, 8, cell width and I/O byte width
CODE_BITWIDTH, 16, instruction word width
ADDR_BITWIDTH, 16, width of pc (code_addr), dp (data_addr) and bracket depth counter

Ports:
clk  in  1  single system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
code_addr  out  ADDR_BITWIDTH  program counter (pc) to ROM
code_in  in  CODE_BITWIDTH  instruction at code_addr (combinational, same cycle)
data_addr  out  ADDR_BITWIDTH  data pointer (dp) to RAM read and write address
data_in  in  DATA_BITWIDTH  RAM cell at data_addr (combinational)
data_out  out  DATA_BITWIDTH  RAM write data; also output byte to the tx side
data_wr  out  1  RAM write strobe, level-sensitive
io_input_data  in  DATA_BITWIDTH  input byte, valid when io_input_ready=1
io_input_ready  in  1  input byte strobe (may be a 1-cycle pulse)
io_input_done  out  1  1-cycle pulse when the buffered input byte is consumed
io_output_ready  out  1  output byte valid on data_out
io_output_done  in  1  tx side accepted the byte (level, may last several cycles)
dbg_clk  in  1  reserved debug input; must have no functional effect

Behaviour:
- Reset (rst=1 at clk edge): pc=0, dp=0, state=EXEC, input buffer empty, depth=0. data_wr=0, io_input_done=0, io_output_ready=0. RAM contents untouched.
- Opcode is code_in[7:0] (ASCII); code_in[15:8] is ignored.
  - '>'=0x3E, '<'=0x3C, '+'=0x2B, '-'=0x2D, '.'=0x2E, ','=0x2C, '['=0x5B, ']'=0x5D.
  - 0x00 = HALT.
  - Any other value = NOP: pc+1, 1 cycle.
- pc and dp arithmetic wraps mod 2^ADDR_BITWIDTH. Cell arithmetic wraps mod 2^DATA_BITWIDTH.
- data_out = wval register while state=WRITE, otherwise data_in.
- States: EXEC, WRITE, IN_WAIT, OUT_WAIT, OUT_REL, SCAN_F, SCAN_B, HALT.
- EXEC, decode code_in:
  - '>' / '<': dp±1, pc+1. 1 cycle.
  - '+' / '-': wval = data_in±1, go WRITE. 2 cycles total.
  - ',': go IN_WAIT.
  - '.': assert io_output_ready, go OUT_WAIT.
  - '[': if data_in==0, depth=1, pc+1, go SCAN_F; else pc+1.
  - ']': if data_in!=0, depth=1, pc-1, go SCAN_B; else pc+1.
  - 0x00: go HALT.
- WRITE: data_wr=1 for exactly one cycle with data_addr and data_out stable, pc+1, back to EXEC. dp never changes while data_wr=1.
- Input buffer:
  - Any cycle with io_input_ready=1 loads io_input_data into a 1-entry buffer and sets full; a later strobe before consumption overwrites it.
  - IN_WAIT waits until full (a same-cycle strobe counts). It then sets wval=byte, clears full, pulses io_input_done for 1 cycle and goes to WRITE.
- Output:
  - OUT_WAIT holds io_output_ready=1 with data_out=cell until io_output_done=1.
  - It then drops ready and goes to OUT_REL, which waits for io_output_done=0, then pc+1 and back to EXEC.
  - A long done pulse therefore counts once.
- SCAN_F, one instruction per cycle:
  - '[' → depth+1.
  - ']' → if depth==1, pc+1 and go EXEC; else depth-1.
  - 0x00 → HALT.
  - pc+1 on every non-terminating step.
- SCAN_B, mirror of SCAN_F walking backwards:
  - ']' → depth+1.
  - '[' → if depth==1, pc+1 (instruction after the matching '['), go EXEC; else depth-1.
  - 0x00 → HALT.
- HALT: all outputs inactive, pc/dp frozen until rst.
- Reset mid-operation: aborts any wait or scan. io_output_ready and data_wr drop on the reset edge. The input buffer is cleared.

Test Plan:
1. rst high 2 cycles → code_addr=0, data_addr=0, data_wr=0, io_output_ready=0, io_input_done=0.
2. ROM ",..",0x0000; 1-cycle io_input_ready with 0xAA → one data_wr pulse writing 0xAA to cell 0 and one io_input_done pulse. Then two io_output_ready phases with data_out=0xAA, each ending only after io_output_done high then low (done held 2 cycles counts once). Then code_addr=3 frozen.
3. Repeat scenario 2 with byte 0xEE strobed 20 cycles before ',' is reached → buffered; both outputs 0xEE.
4. "+++>--." → cell0=0x03, cell1=0xFE, output 0xFE, data_addr=1.
5. "+++[->++<]>." → cell0=0, cell1=0x06, output 0x06; '<' at dp=0 ("<." variant) gives data_addr=0xFFFF.
6. "[[+]+]." with cell0=0 → nested forward skip, no writes, output 0x00; unmatched "[" over zero cell reaching 0x0000 → HALT.
